sram_scan_ctrl: RTL and testbench

Parametrised scan-chain controller for the OpenRAM test chip. It sits between the GPIO scan pins and the SRAM macro mux. A serially loaded command frame drives up to NPORTS SRAM ports. Compared with the fixed 112-bit dual-port chain it adds:
- configurable field widths and port count;
- multi-beat bursts with address auto-increment;
- on-chip readback compare with a sticky mismatch flag and an error counter.

---
 rtl/sram_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_sram_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_scan_ctrl.sv
// sram_scan_ctrl: serial scan-chain controller for the OpenRAM test chip SRAM mux.
// A command frame {sel, burst_len, port0, port1..} is shifted in through scan_in
// and executed on go. Each beat issues one access per port for one cycle and then
// captures read data for one cycle. Read data can be compared against the frame din
// fields, and it can be copied back into the chain for scan-out.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   scan_en, scan_in, scan_out      serial chain shift / data
//   sram_load                       copy captured read data into chain din fields
//   go                              start the operation held in the chain
//   compare_en, err_clr             readback compare enable, clear of error state
//   busy, done                      operation in progress, end-of-operation pulse
//   mismatch, err_count             sticky compare fail, saturating error count
//   sram_sel/csb/web/wmask/addr/din macro interface outputs (registered)
//   sram_dout                       read data from the selected macro
module sram_scan_ctrl #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MASK_W  = 4,
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned BURST_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scan_en,
  input  logic                       scan_in,
  output logic                       scan_out,
  input  logic                       sram_load,
  input  logic                       go,
  input  logic                       compare_en,
  input  logic                       err_clr,
  output logic                       busy,
  output logic                       done,
  output logic                       mismatch,
  output logic [15:0]                err_count,
  output logic [SEL_W-1:0]           sram_sel,
  output logic [NPORTS-1:0]          sram_csb,
  output logic [NPORTS-1:0]          sram_web,
  output logic [NPORTS*MASK_W-1:0]   sram_wmask,
  output logic [NPORTS*ADDR_W-1:0]   sram_addr,
  output logic [NPORTS*DATA_W-1:0]   sram_din,
  input  logic [NPORTS*DATA_W-1:0]   sram_dout
);

  localparam int unsigned PORT_W  = ADDR_W + DATA_W + 2 + MASK_W;
  localparam int unsigned CHAIN_W = SEL_W + BURST_W + NPORTS * PORT_W;

  // Field offsets inside one port field {addr, din, csb, web, wmask}
  localparam int unsigned OffWmask = 0;
  localparam int unsigned OffWeb   = MASK_W;
  localparam int unsigned OffCsb   = MASK_W + 1;
  localparam int unsigned OffDin   = MASK_W + 2;
  localparam int unsigned OffAddr  = MASK_W + 2 + DATA_W;
  localparam int unsigned OffBurst = NPORTS * PORT_W;
  localparam int unsigned OffSel   = OffBurst + BURST_W;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e                     state_q, state_d;
  logic [CHAIN_W-1:0]         chain_q, chain_d;
  logic [CHAIN_W-1:0]         frame_q, frame_d;
  logic [BURST_W-1:0]         beat_q, beat_d;
  logic [NPORTS*DATA_W-1:0]   dout_q, dout_d;
  logic                       mismatch_q, mismatch_d;
  logic [15:0]                err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [NPORTS-1:0]          csb_q, csb_d;
  logic [NPORTS-1:0]          web_q, web_d;
  logic [NPORTS*MASK_W-1:0]   wmask_q, wmask_d;
  logic [NPORTS*ADDR_W-1:0]   addr_q, addr_d;
  logic [NPORTS*DATA_W-1:0]   din_q, din_d;
  logic [1:0]                 fail_cnt;
  logic [16:0]                err_sum;

  always_comb begin
    state_d    = state_q;
    chain_d    = chain_q;
    frame_d    = frame_q;
    beat_d     = beat_q;
    dout_d     = dout_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    done_d     = 1'b0;
    sel_d      = sel_q;
    csb_d      = '1;
    web_d      = '1;
    wmask_d    = wmask_q;
    addr_d     = addr_q;
    din_d      = din_q;
    fail_cnt   = '0;
    err_sum    = '0;

    case (state_q)
      StIdle: begin
        if (scan_en) begin
          chain_d = {chain_q[CHAIN_W-2:0], scan_in};
        end else if (go) begin
          state_d = StIssue;
          frame_d = chain_q;
          beat_d  = '0;
        end else if (sram_load) begin
          for (int unsigned p = 0; p < NPORTS; p++) begin
            chain_d[(NPORTS-1-p)*PORT_W + OffDin +: DATA_W] = dout_q[p*DATA_W +: DATA_W];
          end
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
          // Only selected read ports capture and compare
          if (!frame_q[(NPORTS-1-p)*PORT_W + OffCsb] && frame_q[(NPORTS-1-p)*PORT_W + OffWeb]) begin
            dout_d[p*DATA_W +: DATA_W] = sram_dout[p*DATA_W +: DATA_W];
            if (compare_en && (sram_dout[p*DATA_W +: DATA_W] !=
                               frame_q[(NPORTS-1-p)*PORT_W + OffDin +: DATA_W])) begin
              fail_cnt = fail_cnt + 2'd1;
            end
          end
        end
        if (beat_q == frame_q[OffBurst +: BURST_W]) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          beat_d  = beat_q + 1'b1;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase

    err_sum = {1'b0, err_q} + 17'(fail_cnt);
    if (fail_cnt != 2'd0) begin
      mismatch_d = 1'b1;
      err_d      = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
    // Clear wins over a coincident increment
    if (err_clr) begin
      mismatch_d = 1'b0;
      err_d      = '0;
    end

    busy_d = (state_d != StIdle);

    if (state_q == StIdle && state_d == StIssue) begin
      sel_d = frame_d[OffSel +: SEL_W];
    end

    // Outputs are registered, so they are computed from the next-state frame/beat
    if (state_d == StIssue) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        csb_d[p]                     = frame_d[(NPORTS-1-p)*PORT_W + OffCsb];
        web_d[p]                     = frame_d[(NPORTS-1-p)*PORT_W + OffWeb];
        wmask_d[p*MASK_W +: MASK_W]  = frame_d[(NPORTS-1-p)*PORT_W + OffWmask +: MASK_W];
        din_d[p*DATA_W +: DATA_W]    = frame_d[(NPORTS-1-p)*PORT_W + OffDin +: DATA_W];
        addr_d[p*ADDR_W +: ADDR_W]   = frame_d[(NPORTS-1-p)*PORT_W + OffAddr +: ADDR_W] +
                                       ADDR_W'(beat_d);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      chain_q    <= '0;
      frame_q    <= '0;
      beat_q     <= '0;
      dout_q     <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= '0;
      csb_q      <= '1;
      web_q      <= '1;
      wmask_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      frame_q    <= frame_d;
      beat_q     <= beat_d;
      dout_q     <= dout_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sel_q      <= sel_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign scan_out   = chain_q[CHAIN_W-1];
  assign busy       = busy_q;
  assign done       = done_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign sram_sel   = sel_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// Self-checking bench for sram_scan_ctrl at default parameters. A behavioural
// dual-port SRAM answers the controller; issued beats are checked against a
// scoreboard queue filled when each operation is launched.
module tb_sram_scan_ctrl;

  localparam int CHAIN_W = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_en, scan_in, scan_out, sram_load, go, compare_en, err_clr;
  logic        busy, done, mismatch;
  logic [15:0] err_count;
  logic [3:0]  sram_sel;
  logic [1:0]  sram_csb, sram_web;
  logic [7:0]  sram_wmask;
  logic [31:0] sram_addr;
  logic [63:0] sram_din;
  logic [63:0] sram_dout = '0;

  always #5 clk = ~clk;

  sram_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .sram_load  (sram_load),
    .go         (go),
    .compare_en (compare_en),
    .err_clr    (err_clr),
    .busy       (busy),
    .done       (done),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .sram_sel   (sram_sel),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Behavioural SRAM shared by both ports, byte-wide write mask
  logic [31:0] mem [int];
  logic [31:0] m_cur;
  int          m_a;
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!sram_csb[p]) begin
        m_a   = int'(sram_addr[p*16 +: 16]);
        m_cur = mem.exists(m_a) ? mem[m_a] : 32'h0;
        if (!sram_web[p]) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask[p*4+b]) m_cur[b*8 +: 8] = sram_din[p*32 + b*8 +: 8];
          mem[m_a] = m_cur;
        end else begin
          sram_dout[p*32 +: 32] <= m_cur;
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  burst;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  csb, web;
    logic [3:0]  wm0, wm1;
    logic        ce;
    logic        exp_mm;
    logic [15:0] exp_err;
  } vec_t;

  typedef struct packed {
    logic [1:0]  csb, web;
    logic [31:0] addr;
    logic [63:0] din;
    logic [7:0]  wm;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    n_cmp = 0, n_fail = 0;
  int    issue_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (sram_csb != 2'b11) begin
      issue_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_issue: got addr %0h expected no access", sram_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("issue_csb", sram_csb, mon_e.csb);
        chk("issue_web", sram_web, mon_e.web);
        chk("issue_addr", sram_addr, mon_e.addr);
        chk("issue_din", sram_din, mon_e.din);
        chk("issue_wmask", sram_wmask, mon_e.wm);
      end
    end
  end

  function automatic logic [CHAIN_W-1:0] pack(input vec_t v);
    return {v.sel, v.burst, v.a0, v.d0, v.csb[0], v.web[0], v.wm0,
            v.a1, v.d1, v.csb[1], v.web[1], v.wm1};
  endfunction

  task automatic push_beats(input vec_t v);
    beat_t e;
    for (int b = 0; b <= int'(v.burst); b++) begin
      e.csb  = v.csb;
      e.web  = v.web;
      e.addr = {16'(v.a1 + 16'(b)), 16'(v.a0 + 16'(b))};
      e.din  = {v.d1, v.d0};
      e.wm   = {v.wm1, v.wm0};
      sb.push_back(e);
    end
  endtask

  task automatic shift_frame(input logic [CHAIN_W-1:0] f);
    for (int i = CHAIN_W - 1; i >= 0; i--) begin
      scan_en = 1'b1;
      scan_in = f[i];
      @(posedge clk); #1;
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic read_chain(output logic [CHAIN_W-1:0] f);
    for (int i = CHAIN_W - 1; i >= 0; i--) begin
      f[i]    = scan_out;
      scan_en = 1'b1;
      scan_in = 1'b0;
      @(posedge clk); #1;
    end
    scan_en = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input logic with_load);
    int busy_cnt = 0;
    int seen = 0;
    shift_frame(pack(v));
    push_beats(v);
    compare_en = v.ce;
    go         = 1'b1;
    sram_load  = with_load;
    @(posedge clk); #1;
    go        = 1'b0;
    sram_load = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("busy_cycles", busy_cnt, 2 * (int'(v.burst) + 1));
    chk("done_seen", seen, 1);
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    @(posedge clk); #1;
  endtask

  vec_t             tbl[8];
  vec_t             v;
  logic [CHAIN_W-1:0] got, expf;
  int               start, dc0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          sel   burst  a0       a1       d0            d1            csb    web    wm0   wm1  ce  mm  err
    tbl[0] = '{4'h0, 8'd0, 16'h1,    16'h0,   32'h1,        32'h0,        2'b10, 2'b10, 4'hF, 4'h0, 0, 0, 16'd0};
    tbl[1] = '{4'h0, 8'd0, 16'h1,    16'h0,   32'h1,        32'h0,        2'b10, 2'b11, 4'h0, 4'h0, 1, 0, 16'd0};
    tbl[2] = '{4'h3, 8'd3, 16'h8,    16'h100, 32'hDEADBEEF, 32'h12345678, 2'b00, 2'b00, 4'hF, 4'hF, 1, 0, 16'd0};
    tbl[3] = '{4'h3, 8'd3, 16'h8,    16'h100, 32'hDEADBEEF, 32'h12345678, 2'b00, 2'b11, 4'h0, 4'h0, 1, 0, 16'd0};
    tbl[4] = '{4'h3, 8'd3, 16'h8,    16'h8,   32'hDEADBEEE, 32'hDEADBEEE, 2'b00, 2'b11, 4'h0, 4'h0, 1, 1, 16'd8};
    tbl[5] = '{4'h3, 8'd3, 16'h8,    16'h8,   32'h0,        32'h0,        2'b00, 2'b11, 4'h0, 4'h0, 0, 1, 16'd8};
    tbl[6] = '{4'h1, 8'd0, 16'h40,   16'h0,   32'hFFFFFFFF, 32'h0,        2'b10, 2'b10, 4'h1, 4'h0, 1, 1, 16'd8};
    tbl[7] = '{4'h1, 8'd0, 16'h40,   16'h0,   32'h000000FF, 32'h0,        2'b10, 2'b11, 4'h0, 4'h0, 1, 1, 16'd8};

    reset = 1'b1; scan_en = 0; scan_in = 0; sram_load = 0; go = 0; compare_en = 0; err_clr = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_scan_out", scan_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mismatch", mismatch, 1'b0);
    chk("rst_err_count", err_count, 16'h0);
    chk("rst_csb", sram_csb, 2'b11);
    chk("rst_web", sram_web, 2'b11);
    chk("rst_addr_din_wmask_sel", {sram_addr, sram_din, sram_wmask, sram_sel}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Loopback: pattern comes back MSB first
    expf = {15{8'hA5}};
    shift_frame(expf);
    read_chain(got);
    chk("loopback", got, expf);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i], 1'b0);
      chk($sformatf("tbl%0d_sel", i), sram_sel, tbl[i].sel);
      chk($sformatf("tbl%0d_mismatch", i), mismatch, tbl[i].exp_mm);
      chk($sformatf("tbl%0d_err_count", i), err_count, tbl[i].exp_err);
    end

    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr_mismatch", mismatch, 1'b0);
    chk("err_clr_count", err_count, 16'h0);

    // Readback through sram_load: port1 keeps data captured by tbl[5]'s last beat
    v = '{4'h0, 8'd0, 16'h1, 16'h200, 32'h0, 32'h0, 2'b10, 2'b11, 4'h0, 4'h0, 0, 0, 16'd0};
    run_op(v, 1'b0);
    sram_load = 1'b1;
    @(posedge clk); #1;
    sram_load = 1'b0;
    read_chain(got);
    v.d0 = 32'h1;
    v.d1 = 32'hDEADBEEF;
    chk("sram_load_chain", got, pack(v));
    chk("sram_load_err_count", err_count, 16'h0);

    // go with scan_en: shift wins, no access
    v = tbl[1];
    shift_frame(pack(v));
    start    = issue_cnt;
    scan_en  = 1'b1;
    scan_in  = 1'b1;
    go       = 1'b1;
    @(posedge clk); #1;
    scan_en = 1'b0; scan_in = 1'b0; go = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("prio_scan_no_issue", issue_cnt - start, 0);
    chk("prio_scan_busy", busy, 1'b0);
    read_chain(got);
    expf = pack(v);
    expf = {expf[CHAIN_W-2:0], 1'b1};
    chk("prio_scan_chain", got, expf);

    // go with sram_load: op runs, chain din fields untouched
    v = '{4'h2, 8'd0, 16'h20, 16'h0, 32'h55, 32'h0, 2'b10, 2'b10, 4'hF, 4'h0, 0, 0, 16'd0};
    run_op(v, 1'b1);
    read_chain(got);
    chk("prio_load_chain", got, pack(v));

    // Address wrap across 0xFFFF
    v = '{4'h0, 8'd2, 16'hFFFF, 16'h0, 32'hCAFE, 32'h0, 2'b10, 2'b10, 4'hF, 4'h0, 0, 0, 16'd0};
    run_op(v, 1'b0);

    // Reset in the middle of the second beat's ISSUE cycle
    v.web = 2'b11;
    shift_frame(pack(v));
    push_beats(v);
    start = issue_cnt;
    go    = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (issue_cnt - start == 2) break;
    end
    chk("wrap_reset_reached", issue_cnt - start, 2);
    chk("wrap_pre_reset_csb", sram_csb, 2'b10);
    chk("wrap_pre_reset_addr", sram_addr[15:0], 16'h0000);
    dc0   = done_cnt;
    reset = 1'b1;
    #1;
    chk("reset_async_csb", sram_csb, 2'b11);
    chk("reset_async_busy", busy, 1'b0);
    chk("reset_async_done", done, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_no_done", done_cnt - dc0, 0);
    chk("reset_idle_busy", busy, 1'b0);
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
